// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the run-level phase sequencer.
// Holds state/error encodings, phase IDs and default counter widths.
package core_ctrl_pkg;

    localparam int TIMEOUT_W_DEF = 16;
    localparam int ITER_W_DEF    = 8;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_PC_RUN   = 3'd1,
        SEQ_MCMC_RUN = 3'd2,
        SEQ_DCTC_RUN = 3'd3,
        SEQ_DONE     = 3'd4,
        SEQ_ERROR    = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ABORT   = 2'd2
    } err_code_t;

    localparam logic [1:0] PHASE_NONE = 2'd0;
    localparam logic [1:0] PHASE_PC   = 2'd1;
    localparam logic [1:0] PHASE_MCMC = 2'd2;
    localparam logic [1:0] PHASE_DCTC = 2'd3;

    // Maps a run state to the phase ID reported with an error.
    function automatic logic [1:0] phase_of(seq_state_t s);
        case (s)
            SEQ_PC_RUN:   return PHASE_PC;
            SEQ_MCMC_RUN: return PHASE_MCMC;
            SEQ_DCTC_RUN: return PHASE_DCTC;
            default:      return PHASE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle watchdog, shared by all phases of the sequencer.
// Counts enabled cycles since the last clear; a limit of 0 disables it.
module phase_watchdog
    import core_ctrl_pkg::*;
#(
    parameter int WIDTH = TIMEOUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;
    logic             at_limit;

    // The last allowed cycle is count == limit-1, so a phase gets exactly limit cycles.
    assign at_limit = (limit != '0) && (count == limit - WIDTH'(1));
    assign expired  = enable && at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_limit) begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Run-level controller: sequences parameter calculation, N MCMC passes and DCTC,
// with a shared per-phase watchdog, abort handling and registered status outputs.
module phase_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF,
    parameter int ITER_W    = ITER_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_core,
    input  logic                 abort,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic [ITER_W-1:0]    cfg_mcmc_iters,
    input  logic                 param_calc_finish,
    input  logic                 mcmc_finish,
    input  logic                 dctc_finish,
    output logic                 param_calc_start,
    output logic                 mcmc_start,
    output logic                 dctc_start,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 core_done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [1:0]           err_phase
);

    seq_state_t           state_q;
    err_code_t            err_code_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [ITER_W-1:0]    iters_q;
    logic [ITER_W-1:0]    iter_cnt;

    logic run_state;
    logic active_finish;
    logic launch;
    logic wd_clear;
    logic wd_expired;
    logic timeout_hit;

    assign state    = state_q;
    assign err_code = err_code_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        run_state     = 1'b0;
        active_finish = 1'b0;
        case (state_q)
            SEQ_PC_RUN: begin
                run_state     = 1'b1;
                active_finish = param_calc_finish;
            end
            SEQ_MCMC_RUN: begin
                run_state     = 1'b1;
                active_finish = mcmc_finish;
            end
            SEQ_DCTC_RUN: begin
                run_state     = 1'b1;
                active_finish = dctc_finish;
            end
            default: ;
        endcase
        launch      = start_core && (state_q == SEQ_IDLE || state_q == SEQ_ERROR);
        // The timer restarts on run launch and on every phase or pass entry.
        wd_clear    = launch || (run_state && active_finish);
        timeout_hit = wd_expired && !active_finish;
    end

    phase_watchdog #(
        .WIDTH (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (run_state),
        .limit   (timeout_q),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= SEQ_IDLE;
            param_calc_start <= 1'b0;
            mcmc_start       <= 1'b0;
            dctc_start       <= 1'b0;
            busy             <= 1'b0;
            core_done        <= 1'b0;
            error            <= 1'b0;
            err_code_q       <= ERR_NONE;
            err_phase        <= PHASE_NONE;
            timeout_q        <= '0;
            iters_q          <= '0;
            iter_cnt         <= '0;
        end else begin
            param_calc_start <= 1'b0;
            mcmc_start       <= 1'b0;
            dctc_start       <= 1'b0;
            core_done        <= 1'b0;

            // Abort outranks timeout, which only fires when the phase's finish is low.
            if (run_state && abort) begin
                state_q    <= SEQ_ERROR;
                busy       <= 1'b0;
                error      <= 1'b1;
                err_code_q <= ERR_ABORT;
                err_phase  <= phase_of(state_q);
            end else if (run_state && timeout_hit) begin
                state_q    <= SEQ_ERROR;
                busy       <= 1'b0;
                error      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
                err_phase  <= phase_of(state_q);
            end else begin
                case (state_q)
                    SEQ_IDLE, SEQ_ERROR: begin
                        if (start_core) begin
                            state_q          <= SEQ_PC_RUN;
                            busy             <= 1'b1;
                            error            <= 1'b0;
                            err_code_q       <= ERR_NONE;
                            err_phase        <= PHASE_NONE;
                            timeout_q        <= cfg_timeout;
                            iters_q          <= (cfg_mcmc_iters == '0) ? ITER_W'(1) : cfg_mcmc_iters;
                            iter_cnt         <= '0;
                            param_calc_start <= 1'b1;
                        end
                    end
                    SEQ_PC_RUN: begin
                        if (param_calc_finish) begin
                            state_q    <= SEQ_MCMC_RUN;
                            iter_cnt   <= ITER_W'(1);
                            mcmc_start <= 1'b1;
                        end
                    end
                    SEQ_MCMC_RUN: begin
                        if (mcmc_finish) begin
                            if (iter_cnt < iters_q) begin
                                iter_cnt   <= iter_cnt + ITER_W'(1);
                                mcmc_start <= 1'b1;
                            end else begin
                                state_q    <= SEQ_DCTC_RUN;
                                dctc_start <= 1'b1;
                            end
                        end
                    end
                    SEQ_DCTC_RUN: begin
                        if (dctc_finish) begin
                            state_q   <= SEQ_DONE;
                            busy      <= 1'b0;
                            core_done <= 1'b1;
                        end
                    end
                    SEQ_DONE: begin
                        state_q <= SEQ_IDLE;
                    end
                    default: begin
                        state_q <= SEQ_IDLE;
                        busy    <= 1'b0;
                        error   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: a table of single-cycle vectors
// plus directed multi-cycle sequences for runs, timeouts, races and reset.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_core;
    logic        abort;
    logic [15:0] cfg_timeout;
    logic [7:0]  cfg_mcmc_iters;
    logic        param_calc_finish;
    logic        mcmc_finish;
    logic        dctc_finish;
    logic        param_calc_start;
    logic        mcmc_start;
    logic        dctc_start;
    logic [2:0]  state;
    logic        busy;
    logic        core_done;
    logic        error;
    logic [1:0]  err_code;
    logic [1:0]  err_phase;

    int checks   = 0;
    int failures = 0;

    phase_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start_core        (start_core),
        .abort             (abort),
        .cfg_timeout       (cfg_timeout),
        .cfg_mcmc_iters    (cfg_mcmc_iters),
        .param_calc_finish (param_calc_finish),
        .mcmc_finish       (mcmc_finish),
        .dctc_finish       (dctc_finish),
        .param_calc_start  (param_calc_start),
        .mcmc_start        (mcmc_start),
        .dctc_start        (dctc_start),
        .state             (state),
        .busy              (busy),
        .core_done         (core_done),
        .error             (error),
        .err_code          (err_code),
        .err_phase         (err_phase)
    );

    always #5 clk = ~clk;

    // Packed view: {state, pc_start, mcmc_start, dctc_start, busy, done, error, code, phase}
    typedef struct {
        logic        start;
        logic        abrt;
        logic        pcf;
        logic        mf;
        logic        df;
        logic [12:0] exp;
    } vec_t;

    function automatic logic [12:0] pack(logic [2:0] st, logic pcs, logic ms, logic ds,
                                         logic bsy, logic dn, logic er, logic [1:0] code,
                                         logic [1:0] ph);
        return {st, pcs, ms, ds, bsy, dn, er, code, ph};
    endfunction

    function automatic vec_t mk(logic s, logic a, logic p, logic m, logic d, logic [12:0] e);
        vec_t v;
        v.start = s; v.abrt = a; v.pcf = p; v.mf = m; v.df = d; v.exp = e;
        return v;
    endfunction

    function automatic logic [12:0] obs();
        return pack(state, param_calc_start, mcmc_start, dctc_start, busy, core_done,
                    error, err_code, err_phase);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_core = 0; abort = 0;
        param_calc_finish = 0; mcmc_finish = 0; dctc_finish = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Launches a run and models engines that finish lat cycles after their start pulse.
    task automatic run_engines(input int lat, input int budget,
                               output int n_pc, output int n_mc, output int n_dc,
                               output int n_done, output int done_cyc, output int n_err,
                               output logic busy_at_done);
        int cd;
        int eng;
        n_pc = 0; n_mc = 0; n_dc = 0; n_done = 0; n_err = 0;
        done_cyc = -1; cd = 0; eng = 0; busy_at_done = 1'b1;
        start_core = 1;
        tick();
        start_core = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            param_calc_finish = 0; mcmc_finish = 0; dctc_finish = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    case (eng)
                        1: param_calc_finish = 1;
                        2: mcmc_finish = 1;
                        default: dctc_finish = 1;
                    endcase
                end
            end
            if (param_calc_start) begin n_pc++; cd = lat; eng = 1; end
            if (mcmc_start)       begin n_mc++; cd = lat; eng = 2; end
            if (dctc_start)       begin n_dc++; cd = lat; eng = 3; end
            if (core_done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = busy;
                end
            end
            if (error) n_err++;
            if (state == 3'd0 && done_cyc >= 0) break;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        vec_t vecs[19];
        int   n_pc, n_mc, n_dc, n_done, done_cyc, n_err;
        logic busy_at_done;
        int   k;

        cfg_timeout    = 16'd0;
        cfg_mcmc_iters = 8'd2;
        do_reset();
        check("reset_state", 32'(obs()), 32'(pack(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)));

        // ---- table: iters = 2, watchdog disabled ----
        vecs[0]  = mk(0, 0, 1, 1, 1, pack(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        vecs[1]  = mk(1, 0, 0, 0, 0, pack(3'd1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[2]  = mk(1, 0, 0, 0, 1, pack(3'd1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[3]  = mk(0, 0, 0, 0, 0, pack(3'd1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[4]  = mk(0, 0, 1, 0, 0, pack(3'd2, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[5]  = mk(0, 0, 0, 1, 0, pack(3'd2, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[6]  = mk(0, 0, 1, 0, 0, pack(3'd2, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[7]  = mk(0, 0, 0, 1, 0, pack(3'd3, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0));
        vecs[8]  = mk(0, 0, 0, 1, 0, pack(3'd3, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[9]  = mk(0, 0, 0, 0, 1, pack(3'd4, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0));
        vecs[10] = mk(1, 0, 0, 0, 0, pack(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        vecs[11] = mk(0, 1, 0, 0, 0, pack(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
        vecs[12] = mk(1, 0, 0, 0, 0, pack(3'd1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[13] = mk(0, 1, 1, 0, 0, pack(3'd5, 0, 0, 0, 0, 0, 1, 2'd2, 2'd1));
        vecs[14] = mk(0, 1, 0, 0, 0, pack(3'd5, 0, 0, 0, 0, 0, 1, 2'd2, 2'd1));
        vecs[15] = mk(1, 0, 0, 0, 0, pack(3'd1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[16] = mk(0, 0, 1, 0, 0, pack(3'd2, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0));
        vecs[17] = mk(0, 1, 0, 1, 0, pack(3'd5, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2));
        vecs[18] = mk(0, 0, 1, 1, 1, pack(3'd5, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2));

        for (int i = 0; i < 19; i++) begin
            start_core        = vecs[i].start;
            abort             = vecs[i].abrt;
            param_calc_finish = vecs[i].pcf;
            mcmc_finish       = vecs[i].mf;
            dctc_finish       = vecs[i].df;
            tick();
            check($sformatf("vec[%0d]", i), 32'(obs()), 32'(vecs[i].exp));
        end
        idle_inputs();

        // ---- nominal run: iters = 3, timeout = 100, finish 5 cycles after start ----
        do_reset();
        cfg_timeout    = 16'd100;
        cfg_mcmc_iters = 8'd3;
        run_engines(5, 200, n_pc, n_mc, n_dc, n_done, done_cyc, n_err, busy_at_done);
        check("nom_pc_starts", 32'(n_pc), 32'd1);
        check("nom_mcmc_starts", 32'(n_mc), 32'd3);
        check("nom_dctc_starts", 32'(n_dc), 32'd1);
        check("nom_done_pulses", 32'(n_done), 32'd1);
        check("nom_done_cycle", 32'(done_cyc), 32'd30);
        check("nom_busy_at_done", 32'(busy_at_done), 32'd0);
        check("nom_errors", 32'(n_err), 32'd0);
        check("nom_final", 32'(obs()), 32'(pack(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)));

        // ---- iters = 0 behaves as one pass ----
        cfg_mcmc_iters = 8'd0;
        run_engines(2, 200, n_pc, n_mc, n_dc, n_done, done_cyc, n_err, busy_at_done);
        check("it0_mcmc_starts", 32'(n_mc), 32'd1);
        check("it0_dctc_starts", 32'(n_dc), 32'd1);
        check("it0_done_cycle", 32'(done_cyc), 32'd9);

        // ---- timeout in MCMC: timeout = 10, mcmc_finish never comes ----
        cfg_timeout    = 16'd10;
        cfg_mcmc_iters = 8'd3;
        start_core = 1; tick(); start_core = 0;
        tick();
        param_calc_finish = 1; tick(); param_calc_finish = 0;
        check("to_mcmc_start", 32'(mcmc_start), 32'd1);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (error) begin k = c; break; end
        end
        check("to_latency", 32'(k), 32'd10);
        check("to_error_state", 32'(obs()), 32'(pack(3'd5, 0, 0, 0, 0, 0, 1, 2'd1, 2'd2)));
        start_core = 1; tick(); start_core = 0;
        check("to_restart", 32'(obs()), 32'(pack(3'd1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0)));

        // ---- race: abort with dctc_finish in the same cycle ----
        do_reset();
        cfg_timeout    = 16'd0;
        cfg_mcmc_iters = 8'd1;
        start_core = 1; tick(); start_core = 0;
        param_calc_finish = 1; tick(); param_calc_finish = 0;
        mcmc_finish = 1; tick(); mcmc_finish = 0;
        check("race_dctc_start", 32'(obs()), 32'(pack(3'd3, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0)));
        abort = 1; dctc_finish = 1; tick(); abort = 0; dctc_finish = 0;
        check("race_abort_wins", 32'(obs()), 32'(pack(3'd5, 0, 0, 0, 0, 0, 1, 2'd2, 2'd3)));
        tick();
        check("race_no_done", 32'(core_done), 32'd0);

        // ---- finish arriving on the timeout cycle wins ----
        cfg_timeout = 16'd4;
        start_core = 1; tick(); start_core = 0;
        tick(); tick(); tick();
        check("fin_on_to_pre", 32'(obs()), 32'(pack(3'd1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0)));
        param_calc_finish = 1; tick(); param_calc_finish = 0;
        check("fin_on_to_adv", 32'(obs()), 32'(pack(3'd2, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0)));

        // ---- reset during MCMC pass 2 of 3 ----
        do_reset();
        cfg_timeout    = 16'd0;
        cfg_mcmc_iters = 8'd3;
        start_core = 1; tick(); start_core = 0;
        param_calc_finish = 1; tick(); param_calc_finish = 0;
        mcmc_finish = 1; tick(); mcmc_finish = 0;
        check("rst_pass2", 32'(obs()), 32'(pack(3'd2, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0)));
        tick();
        reset = 1; tick(); reset = 0;
        check("rst_mid_run", 32'(obs()), 32'(pack(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)));
        start_core = 1; tick(); start_core = 0;
        check("rst_restart", 32'(obs()), 32'(pack(3'd1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
